// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store controller driving a
// big-endian byte-lane data RAM with a 3-state request FSM.
// Ports: req_* (request in, ready out), resp_* (result out),
// mem_* (RAM side, mem_rdata combinational), clk, rst (async, active-low).
// Optional LL/SC support: define MEM_ACCESS_LLSC_EN.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;
  localparam logic [3:0] OP_LL  = 4'd8;
  localparam logic [3:0] OP_SC  = 4'd9;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_exc_q, resp_exc_d;
  logic        mem_ce_q, mem_ce_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_sel_q, mem_sel_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
`ifdef MEM_ACCESS_LLSC_EN
  logic        llbit_q, llbit_d;
  logic [29:0] ll_addr_q, ll_addr_d;
  logic        sc_ok;
`endif

  logic        is_byte, is_half, is_store;
  logic        legal, misal;
  logic [1:0]  exc;
  logic [3:0]  sel;
  logic [31:0] wrep;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // request decode
  always_comb begin
    is_byte  = req_op inside {OP_LB, OP_LBU, OP_SB};
    is_half  = req_op inside {OP_LH, OP_LHU, OP_SH};
    is_store = req_op inside {OP_SB, OP_SH, OP_SW, OP_SC};
`ifdef MEM_ACCESS_LLSC_EN
    legal = req_op <= OP_SC;
    sc_ok = llbit_q && (ll_addr_q == req_addr[31:2]);
`else
    legal = req_op <= OP_SW;
`endif
    if (is_byte)
      misal = 1'b0;
    else if (is_half)
      misal = req_addr[0];
    else
      misal = req_addr[1:0] != 2'b00;
    if (!legal)
      exc = 2'b10;
    else if (misal)
      exc = 2'b01;
    else
      exc = 2'b00;
    sel  = 4'b1111;
    wrep = req_wdata;
    unique case (1'b1)
      is_byte: begin
        sel  = 4'b1000 >> req_addr[1:0];
        wrep = {4{req_wdata[7:0]}};
      end
      is_half: begin
        sel  = req_addr[1] ? 4'b0011 : 4'b1100;
        wrep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // lane extraction; lane 0 is the most significant byte
  always_comb begin
    unique case (mem_addr_q[1:0])
      2'd0: rd_byte = mem_rdata[31:24];
      2'd1: rd_byte = mem_rdata[23:16];
      2'd2: rd_byte = mem_rdata[15:8];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = mem_addr_q[1] ? mem_rdata[15:0]
                            : mem_rdata[31:16];
    unique case (op_q)
      OP_LB:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU: rd_ext = {24'h0, rd_byte};
      OP_LH:  rd_ext = {{16{rd_half[15]}}, rd_half};
      OP_LHU: rd_ext = {16'h0, rd_half};
      OP_LW,
      OP_LL:  rd_ext = mem_rdata;
      // a failed SC never raised mem_we, so it doubles as status
      OP_SC:  rd_ext = {31'h0, mem_we_q};
      default: rd_ext = 32'h0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_exc_d   = resp_exc_q;
    mem_ce_d     = mem_ce_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_sel_d    = mem_sel_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef MEM_ACCESS_LLSC_EN
    llbit_d      = llbit_q;
    ll_addr_d    = ll_addr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          if (exc != 2'b00) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_exc_d   = exc;
            resp_rdata_d = 32'h0;
          end else begin
            state_d     = ACCESS;
            mem_ce_d    = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = req_addr;
            mem_sel_d   = sel;
            mem_wdata_d = is_store ? wrep : 32'h0;
          end
`ifdef MEM_ACCESS_LLSC_EN
          if (req_op == OP_SC) begin
            llbit_d = 1'b0;
            if (exc == 2'b00 && !sc_ok) begin
              mem_ce_d    = 1'b0;
              mem_we_d    = 1'b0;
              mem_sel_d   = 4'b0000;
              mem_wdata_d = 32'h0;
            end
          end else if (exc == 2'b00) begin
            if (req_op == OP_LL) begin
              llbit_d   = 1'b1;
              ll_addr_d = req_addr[31:2];
            end else if (is_store &&
                         ll_addr_q == req_addr[31:2]) begin
              llbit_d = 1'b0;
            end
          end
`endif
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_exc_d   = 2'b00;
        resp_rdata_d = rd_ext;
        mem_ce_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = 32'h0;
        mem_sel_d    = 4'b0000;
        mem_wdata_d  = 32'h0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'h0;
          resp_exc_d   = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      op_q         <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_exc_q   <= 2'b00;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_sel_q    <= 4'b0000;
      mem_wdata_q  <= 32'h0;
`ifdef MEM_ACCESS_LLSC_EN
      llbit_q      <= 1'b0;
      ll_addr_q    <= 30'h0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_exc_q   <= resp_exc_d;
      mem_ce_q     <= mem_ce_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_sel_q    <= mem_sel_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef MEM_ACCESS_LLSC_EN
      llbit_q      <= llbit_d;
      ll_addr_q    <= ll_addr_d;
`endif
    end
  end

  // held low while reset is applied so every output reads 0
  assign req_ready  = rst && (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_exc   = resp_exc_q;
  assign mem_ce     = mem_ce_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_sel    = mem_sel_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
